// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - debounce and decode a multiplexed active-low 4-digit seven-segment bus
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_n,
    output logic [15:0] value,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        stale
);

    localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [19:0] TO_MAX  = 20'(TIMEOUT);
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);

    typedef enum logic {
        COLLECT,
        COMMIT
    } state_t;

    function automatic logic dig_valid(input logic [3:0] d);
        return $countones(~d) == 1;
    endfunction

    function automatic logic [1:0] dig_index(input logic [3:0] d);
        case (d)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Returns {err, nibble}; anything that is not one of the 16 glyphs is an error.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h00;
            7'b1111001: return 5'h01;
            7'b0100100: return 5'h02;
            7'b0110000: return 5'h03;
            7'b0011001: return 5'h04;
            7'b0010010: return 5'h05;
            7'b0000010: return 5'h06;
            7'b1111000: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0010000: return 5'h09;
            7'b0001000: return 5'h0A;
            7'b0000011: return 5'h0B;
            7'b1000110: return 5'h0C;
            7'b0100001: return 5'h0D;
            7'b0000110: return 5'h0E;
            7'b0001110: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    logic [6:0]       s_seg_q;
    logic [3:0]       s_dig_q;
    logic [7:0]       cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic [19:0]      tcnt_q, tcnt_d;
    logic [3:0]       seen_q, seen_d;
    state_t           state_q, state_d;
    logic [3:0][3:0]  shadow_q;
    logic [3:0]       shadow_err_q;
    logic [15:0]      value_q;
    logic [3:0]       digit_err_q;
    logic             stale_q, stale_d;

    logic             in_diff;
    logic             capture;
    logic [1:0]       cap_idx;
    logic [4:0]       cap_dec;
    logic [3:0]       cap_bit;
    logic             timeout_hit;
    logic             commit;

    assign capture = (cnt_q == CNT_MAX) && armed_q && dig_valid(s_dig_q);
    assign cap_idx = dig_index(s_dig_q);
    assign cap_dec = decode(s_seg_q);
    assign cap_bit = capture ? (4'b0001 << cap_idx) : 4'b0000;

    always_comb begin
        in_diff = ({seg_n, dig_n} != {s_seg_q, s_dig_q});
        armed_d = armed_q;
        cnt_d   = cnt_q;
        if (in_diff) begin
            armed_d = 1'b1;
        end else if (capture) begin
            armed_d = 1'b0;
        end
        if (!dig_valid(dig_n)) begin
            cnt_d = 8'd0;
        end else if (in_diff) begin
            cnt_d = 8'd1;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires once per idle stretch: the counter saturates one past the trigger value.
    always_comb begin
        timeout_hit = !capture && (tcnt_q == TO_LAST);
        tcnt_d      = tcnt_q;
        if (capture) begin
            tcnt_d = 20'd0;
        end else if (tcnt_q != TO_MAX) begin
            tcnt_d = tcnt_q + 20'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        seen_d      = seen_q;
        stale_d     = stale_q;
        commit      = 1'b0;
        frame_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                seen_d = seen_q | cap_bit;
                if (timeout_hit) begin
                    seen_d  = 4'b0000;
                    stale_d = 1'b1;
                end
                if (seen_d == 4'hF) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // A capture landing here belongs to the next frame.
                commit      = 1'b1;
                frame_valid = 1'b1;
                seen_d      = cap_bit;
                stale_d     = 1'b0;
                state_d     = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg_q      <= 7'h7F;
            s_dig_q      <= 4'hF;
            cnt_q        <= 8'd0;
            armed_q      <= 1'b1;
            tcnt_q       <= 20'd0;
            seen_q       <= 4'b0000;
            shadow_q     <= '0;
            shadow_err_q <= 4'b0000;
            value_q      <= 16'h0000;
            digit_err_q  <= 4'b0000;
            stale_q      <= 1'b1;
        end else begin
            s_seg_q <= seg_n;
            s_dig_q <= dig_n;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            tcnt_q  <= tcnt_d;
            seen_q  <= seen_d;
            stale_q <= stale_d;
            if (capture) begin
                shadow_q[cap_idx]     <= cap_dec[3:0];
                shadow_err_q[cap_idx] <= cap_dec[4];
            end
            if (commit) begin
                value_q     <= shadow_q;
                digit_err_q <= shadow_err_q;
            end
        end
    end

    assign value     = value_q;
    assign digit_err = digit_err_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder against a dwell-level model
module tb_seg_scan_decoder;
    localparam int N = 4;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_n = 4'hF;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        stale;

    seg_scan_decoder #(.STABLE_CYCLES(N), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .seg_n(seg_n), .dig_n(dig_n),
        .value(value), .digit_err(digit_err), .frame_valid(frame_valid), .stale(stale)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_cmp = 0;
    int n_bad = 0;
    int frames_seen = 0;
    int frames_exp = 0;
    logic [19:0] exp_q [$];

    // Model state: what the display reader should know, tracked per capture event.
    logic [3:0]  seen_m;
    logic [15:0] sh_m;
    logic [3:0]  er_m;
    logic        stale_m;
    int          c_last;
    logic [15:0] last_val_m;
    logic [3:0]  last_err_m;
    logic [6:0]  run_seg;
    logic [3:0]  run_dig;
    int          run_start;
    int          run_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (glyph[i] == s) return {1'b0, 4'(i)};
        return 5'h10;
    endfunction

    function automatic bit one_low(input logic [3:0] d);
        return $countones(~d) == 1;
    endfunction

    function automatic int low_pos(input logic [3:0] d);
        for (int i = 0; i < 4; i++) if (!d[i]) return i;
        return 0;
    endfunction

    task automatic model_capture(input int c, input int k, input logic [6:0] s);
        logic [4:0] r;
        if (c - c_last > T) begin
            seen_m  = 4'b0000;
            stale_m = 1'b1;
        end
        r = ref_decode(s);
        sh_m[4*k +: 4] = r[3:0];
        er_m[k]  = r[4];
        seen_m[k] = 1'b1;
        c_last = c;
        if (seen_m == 4'hF) begin
            exp_q.push_back({er_m, sh_m});
            frames_exp++;
            last_val_m = sh_m;
            last_err_m = er_m;
            seen_m  = 4'b0000;
            stale_m = 1'b0;
        end
    endtask

    task automatic dwell(input logic [6:0] s, input logic [3:0] d, input int len);
        int st;
        int old;
        @(negedge clk);
        st = edge_cnt + 1;
        seg_n = s;
        dig_n = d;
        if ({s, d} == {run_seg, run_dig}) begin
            old = run_len;
            run_len += len;
        end else begin
            run_seg = s;
            run_dig = d;
            run_start = st;
            old = 0;
            run_len = len;
        end
        if (one_low(d) && old < N && run_len >= N) model_capture(run_start + N, low_pos(d), s);
        repeat (len - 1) @(negedge clk);
    endtask

    task automatic idle_check(input int len);
        dwell(7'h7F, 4'hF, len);
        chk("stale", 32'(stale), (edge_cnt >= c_last + T) ? 32'd1 : 32'(stale_m));
        chk("value_hold", 32'(value), 32'(last_val_m));
        chk("err_hold", 32'(digit_err), 32'(last_err_m));
    endtask

    task automatic scan(input logic [15:0] v, input int len, input int first, input int last);
        for (int k = first; k <= last; k++) dwell(glyph[v[4*k +: 4]], ~(4'b0001 << k), len);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        seg_n = 7'h7F;
        dig_n = 4'hF;
        @(negedge clk);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_err", 32'(digit_err), 32'h0);
        chk("rst_stale", 32'(stale), 32'h1);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        c_last = edge_cnt;
        seen_m = 4'b0000; sh_m = 16'h0; er_m = 4'b0000; stale_m = 1'b1;
        last_val_m = 16'h0; last_err_m = 4'b0000;
        run_seg = 7'h7F; run_dig = 4'hF; run_start = 0; run_len = 0;
    endtask

    initial begin : monitor
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame_expected: got frame_valid with value 0x%0h, expected no frame", value);
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    chk("frame_value", 32'(value), 32'(e[15:0]));
                    chk("frame_err", 32'(digit_err), 32'(e[19:16]));
                    chk("frame_stale", 32'(stale), 32'h0);
                    chk("fv_pulse", 32'(frame_valid), 32'h0);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no finish within 60000 cycles, expected finish");
        $fatal(1);
    end

    initial begin : stim
        int f0;
        int k;
        int r;
        int len;
        logic [6:0] s;
        logic [3:0] d;
        do_reset();
        idle_check(3);

        scan(16'h1A2F, 6, 0, 3);
        idle_check(4);
        chk("value_1a2f", 32'(value), 32'h1A2F);
        chk("err_1a2f", 32'(digit_err), 32'h0);

        dwell(glyph[4'hF], 4'b1110, 6);
        dwell(glyph[4'h2], 4'b1101, 6);
        dwell(7'h7F, 4'b1011, 6);
        dwell(glyph[4'h1], 4'b0111, 6);
        idle_check(4);
        chk("blank_err", 32'(digit_err), 32'b0100);
        chk("blank_nib", 32'(value[11:8]), 32'h0);

        f0 = frames_seen;
        scan(16'h1A2F, 6, 0, 0);
        scan(16'h1A2F, 3, 1, 1);
        scan(16'h1A2F, 6, 2, 3);
        idle_check(4);
        chk("glitch_no_frame", 32'(frames_seen), 32'(f0));
        scan(16'h1A2F, 6, 0, 3);
        idle_check(4);
        chk("glitch_then_frame", 32'(frames_seen), 32'(f0 + 1));

        f0 = frames_seen;
        dwell(glyph[4'h5], 4'b1100, 10);
        idle_check(4);
        chk("twolow_no_frame", 32'(frames_seen), 32'(f0));
        scan(16'h5C3E, 6, 0, 3);
        idle_check(4);
        chk("twolow_then_frame", 32'(value), 32'h5C3E);

        scan(16'h1A2F, 6, 0, 3);
        idle_check(4);
        f0 = frames_seen;
        scan(16'h7777, 6, 0, 2);
        idle_check(20);
        chk("timeout_stale", 32'(stale), 32'h1);
        chk("timeout_keep", 32'(value), 32'h1A2F);
        chk("timeout_no_frame", 32'(frames_seen), 32'(f0));
        scan(16'h9B0D, 6, 0, 3);
        idle_check(4);
        chk("after_timeout", 32'(value), 32'h9B0D);

        f0 = frames_seen;
        scan(16'h4444, 6, 0, 2);
        do_reset();
        scan(16'h8E61, 6, 3, 3);
        scan(16'h8E61, 6, 0, 1);
        idle_check(4);
        chk("reset_partial", 32'(frames_seen), 32'(f0));
        scan(16'h8E61, 6, 2, 2);
        idle_check(4);
        chk("reset_then_frame", 32'(value), 32'h8E61);

        k = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                idle_check(int'($urandom_range(3, 20)));
            end else begin
                if ($urandom_range(0, 3) != 0) k = (k + 1) % 4;
                else k = int'($urandom_range(0, 3));
                d = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ~(4'b0001 << k);
                s = ($urandom_range(0, 9) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
                len = int'($urandom_range(1, 7));
                dwell(s, d, len);
            end
        end

        idle_check(30);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        chk("frame_count", 32'(frames_seen), 32'(frames_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
